// File: rtl/alu_writeback_regfile.sv
// Writeback stage and register file for the ALU: commits results through a valid/ready
// handshake, holds the status flags, and forwards same-edge writes to both read ports.
module alu_writeback_regfile #(
  parameter int          NUM_REGS = 32,
  parameter int          DATA_W   = 8,
  parameter int          FLAG_W   = 4,
  parameter logic [3:0]  MUL_SEL  = 4'd3,
  parameter logic [3:0]  NOP_SEL  = 4'd0,
  parameter int          CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        func_sel,
  input  logic [4:0]        dest_addr,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] mul_high,
  input  logic [FLAG_W-1:0] sreg_in,
  input  logic [4:0]        rd_addr_a,
  input  logic [4:0]        rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic [FLAG_W-1:0] sreg_out,
  output logic [CNT_W-1:0]  retired
);

  typedef enum logic {IDLE, MUL_HI} state_t;

  state_t              state_reg, state_next;
  logic [DATA_W-1:0]   hold_reg;
  logic [FLAG_W-1:0]   sreg_reg;
  logic [CNT_W-1:0]    retired_reg;
  logic [DATA_W-1:0]   regs [NUM_REGS];

  // Single write port shared by normal commits and the MUL high-byte cycle
  logic                wr_en;
  logic [4:0]          wr_addr;
  logic [DATA_W-1:0]   wr_data;
  logic                commit;
  logic                mul_start;
  logic                dest_in_range;
  logic [NUM_REGS-1:0] wr_sel;

  assign dest_in_range = int'(dest_addr) < NUM_REGS;

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    wr_en      = 1'b0;
    wr_addr    = '0;
    wr_data    = '0;
    commit     = 1'b0;
    mul_start  = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid && func_sel != NOP_SEL) begin
          commit  = 1'b1;
          wr_data = alu_result;
          if (func_sel == MUL_SEL) begin
            wr_en      = 1'b1;
            wr_addr    = 5'd0;
            mul_start  = 1'b1;
            state_next = MUL_HI;
          end else begin
            wr_en   = dest_in_range;
            wr_addr = dest_addr;
          end
        end
      end
      MUL_HI: begin
        wr_en      = 1'b1;
        wr_addr    = 5'd1;
        wr_data    = hold_reg;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // Reset masks everything, including forwarding, which keys off wr_en
    if (reset) begin
      in_ready   = 1'b0;
      wr_en      = 1'b0;
      commit     = 1'b0;
      mul_start  = 1'b0;
      state_next = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      hold_reg    <= '0;
      sreg_reg    <= '0;
      retired_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (mul_start) hold_reg <= mul_high;
      if (commit) begin
        sreg_reg    <= sreg_in;
        retired_reg <= retired_reg + CNT_W'(1);
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_wr_sel
      assign wr_sel[gi] = wr_en && (wr_addr == 5'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REGS; i++) begin
      if (reset)          regs[i] <= '0;
      else if (wr_sel[i]) regs[i] <= wr_data;
    end
  end

  logic [4:0]        rd_addr [2];
  logic [DATA_W-1:0] rd_data [2];

  assign rd_addr[0] = rd_addr_a;
  assign rd_addr[1] = rd_addr_b;

  generate
    for (gi = 0; gi < 2; gi++) begin : g_rd_port
      always_comb begin
        rd_data[gi] = '0;
        if (wr_en && wr_addr == rd_addr[gi])
          rd_data[gi] = wr_data;
        else if (int'(rd_addr[gi]) < NUM_REGS)
          rd_data[gi] = regs[rd_addr[gi]];
      end
    end
  endgenerate

  assign rd_data_a = rd_data[0];
  assign rd_data_b = rd_data[1];
  assign sreg_out  = sreg_reg;
  assign retired   = retired_reg;

endmodule

// File: tb/tb_alu_writeback_regfile.sv
// Scoreboarded bench for alu_writeback_regfile: the driver predicts each cycle's
// visible outputs from an architectural model; a negedge monitor pops and compares.
module tb_alu_writeback_regfile;

  localparam logic [3:0] MUL = 4'd3;
  localparam logic [3:0] NOP = 4'd0;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready;
  logic [3:0]  func_sel, sreg_in, sreg_out;
  logic [4:0]  dest_addr, rd_addr_a, rd_addr_b;
  logic [7:0]  alu_result, mul_high, rd_data_a, rd_data_b;
  logic [15:0] retired;

  always #5 clk = ~clk;

  alu_writeback_regfile dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .func_sel(func_sel), .dest_addr(dest_addr), .alu_result(alu_result),
    .mul_high(mul_high), .sreg_in(sreg_in), .rd_addr_a(rd_addr_a),
    .rd_addr_b(rd_addr_b), .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .sreg_out(sreg_out), .retired(retired)
  );

  typedef struct {
    bit          full;
    bit          rdy;
    logic [7:0]  a, b;
    logic [3:0]  sr;
    logic [15:0] ret;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  // Architectural model: register contents, flags, counter, and a pending high byte
  logic [7:0]  m_mem [32];
  logic [3:0]  m_sreg = '0;
  logic [15:0] m_ret  = '0;
  logic [7:0]  m_hold = '0;
  bit          m_pend = 0;
  bit          m_init = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("[TB] FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("in_ready", int'(in_ready), int'(e.rdy));
      if (e.full) begin
        chk("rd_data_a", int'(rd_data_a), int'(e.a));
        chk("rd_data_b", int'(rd_data_b), int'(e.b));
        chk("sreg_out", int'(sreg_out), int'(e.sr));
        chk("retired", int'(retired), int'(e.ret));
      end
      $display("[TB] cyc rst=%0b v=%0b sel=%0d dst=%0d lo=%02h ra=%0d:%02h rb=%0d:%02h sreg=%0h ret=%0d rdy=%0b",
               reset, in_valid, func_sel, dest_addr, alu_result, rd_addr_a, rd_data_a,
               rd_addr_b, rd_data_b, sreg_out, retired, in_ready);
    end
  end

  function automatic logic [7:0] model_read(input logic [4:0] addr, input bit we,
                                            input logic [4:0] wa, input logic [7:0] wd);
    if (we && wa == addr) return wd;
    return m_mem[addr];
  endfunction

  // Called just after a rising edge: drive inputs, predict this cycle, then advance the model
  task automatic step(input bit rst, input bit v, input logic [3:0] sel, input logic [4:0] dst,
                      input logic [7:0] lo, input logic [7:0] hi, input logic [3:0] sr,
                      input logic [4:0] ra, input logic [4:0] rb);
    exp_t       e;
    bit         xfer, we;
    logic [4:0] wa;
    logic [7:0] wd;
    reset = rst; in_valid = v; func_sel = sel; dest_addr = dst;
    alu_result = lo; mul_high = hi; sreg_in = sr; rd_addr_a = ra; rd_addr_b = rb;

    e.rdy = !rst && !m_pend;
    xfer  = v && e.rdy;
    we = 0; wa = '0; wd = '0;
    if (!rst) begin
      if (m_pend) begin we = 1; wa = 5'd1; wd = m_hold; end
      else if (xfer && sel != NOP) begin
        we = 1; wa = (sel == MUL) ? 5'd0 : dst; wd = lo;
      end
    end
    e.full = m_init;
    e.a    = model_read(ra, we, wa, wd);
    e.b    = model_read(rb, we, wa, wd);
    e.sr   = m_sreg;
    e.ret  = m_ret;
    q.push_back(e);

    if (rst) begin
      foreach (m_mem[i]) m_mem[i] = '0;
      m_sreg = '0; m_ret = '0; m_hold = '0; m_pend = 0; m_init = 1;
    end else begin
      if (xfer && sel != NOP) begin
        m_sreg = sr;
        m_ret  = m_ret + 16'd1;
      end
      if (xfer && sel == MUL) begin
        m_hold = hi;
        m_pend = 1;
      end else begin
        m_pend = 0;
      end
      if (we) m_mem[wa] = wd;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] sel;
    logic [4:0] dst, ra, rb;
    foreach (m_mem[i]) m_mem[i] = '0;
    reset = 1'b1; in_valid = 1'b0; func_sel = '0; dest_addr = '0;
    alu_result = '0; mul_high = '0; sreg_in = '0; rd_addr_a = '0; rd_addr_b = '0;
    @(posedge clk);
    #1;

    step(1, 0, NOP, 0, 8'h00, 8'h00, 4'h0, 0, 0);
    step(1, 1, 4'd1, 9, 8'h55, 8'h00, 4'hF, 9, 9);
    // Every address reads zero after reset
    for (int i = 0; i < 16; i++)
      step(0, 0, NOP, 0, 8'h00, 8'h00, 4'h0, 5'(i), 5'(31 - i));

    step(0, 1, 4'd1, 5, 8'h0F, 8'h00, 4'b0010, 2, 3);
    step(0, 0, NOP, 0, 8'h00, 8'h00, 4'h0, 5, 4);
    step(0, 1, MUL, 9, 8'h03, 8'h3E, 4'b0101, 0, 1);
    step(0, 1, 4'd2, 6, 8'h77, 8'h00, 4'b1000, 1, 0);   // held off by MUL_HI
    step(0, 1, 4'd2, 6, 8'h77, 8'h00, 4'b1000, 6, 1);
    step(0, 1, 4'd4, 7, 8'hAA, 8'h00, 4'b0001, 7, 6);
    step(0, 1, NOP, 7, 8'h12, 8'h34, 4'hF, 7, 0);
    step(0, 0, NOP, 0, 8'h00, 8'h00, 4'h0, 7, 1);
    step(0, 1, MUL, 0, 8'hC1, 8'hD2, 4'hE, 0, 1);
    step(1, 0, NOP, 0, 8'h00, 8'h00, 4'h0, 1, 0);       // reset during MUL_HI
    step(0, 0, NOP, 0, 8'h00, 8'h00, 4'h0, 1, 0);
    step(0, 0, NOP, 0, 8'h00, 8'h00, 4'h0, 5, 7);

    for (int n = 0; n < 3000; n++) begin
      int r;
      r   = $urandom_range(0, 9);
      sel = (r < 2) ? MUL : (r < 3) ? NOP : 4'($urandom_range(1, 15));
      dst = 5'($urandom_range(0, 31));
      ra  = ($urandom_range(0, 3) == 0) ? dst : 5'($urandom_range(0, 31));
      rb  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 1)) : 5'($urandom_range(0, 31));
      step($urandom_range(0, 127) == 0, $urandom_range(0, 3) != 0, sel, dst,
           8'($urandom), 8'($urandom), 4'($urandom), ra, rb);
    end

    @(negedge clk);
    #1;
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
